quad_dir_decoder: RTL and testbench

- Upstream stage for the 2-bit up/down counter: decodes a two-channel quadrature encoder (A/B) into a direction level and a one-cycle step pulse.
- Inputs are asynchronous pins. The block synchronises and debounces them, then tracks Gray-code transitions with a small FSM.
- step_out drives the counter's clock-enable; up_down drives its direction input directly (0 = count up, 1 = count down).
- Illegal two-bit jumps are flagged and counted, never forwarded as steps.

---
 rtl/quad_dir_decoder.sv | 141 ++++++++++++++
 tb/tb_quad_dir_decoder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_dir_decoder.sv
// Quadrature A/B decoder: synchronise, debounce, then classify Gray-code moves.
// Latency: step_out is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1
//   counted from the first edge that samples a new stable pin pair.
// Backpressure: none; pin activity faster than the debounce window is filtered, never queued.
//
// Ports:
//   clk, reset_in (sync, active-high)  a_in/b_in encoder pins (async)
//   err_clr  clears err_count          step_out/illegal_out one-cycle pulses
//   up_down  0 = up, 1 = down          err_count saturating illegal count
//   tracking high once the first stable pair has been accepted
module quad_dir_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_in,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 err_clr,
  output logic                 step_out,
  output logic                 up_down,
  output logic                 illegal_out,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 tracking
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             cand_q, cand_d;
  logic [1:0]             filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   step_q, step_d;
  logic                   ill_q, ill_d;
  logic                   ud_q, ud_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;

  logic [1:0] s_pair;
  logic [1:0] diff;
  logic       pending;
  logic       accept;

  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_in};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_in};
    s_pair   = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

    cand_d  = cand_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    step_d  = 1'b0;
    ill_d   = 1'b0;
    ud_d    = ud_q;
    err_d   = err_q;
    accept  = 1'b0;
    diff    = cand_q ^ filt_q;

    // In INIT the candidate is qualified even when it equals the (reset)
    // filtered pair, so a pair that is stable from reset still gets accepted.
    pending = (cand_q != filt_q) || (state_q == ST_INIT);

    if (s_pair != cand_q) begin
      cand_d = s_pair;
      cnt_d  = '0;
    end else if (pending) begin
      if (cnt_q == CNT_LAST) begin
        accept = 1'b1;
        cnt_d  = '0;
        filt_d = cand_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (accept) begin
      case (state_q)
        ST_INIT: state_d = ST_TRACK;
        default: begin
          if (diff == 2'b11) begin
            ill_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + ERR_CNT_W'(1);
            end
          end else begin
            // Forward moves: when B toggled the new A^B is 1, when A
            // toggled it is 0. Anything else is a reverse move.
            step_d = 1'b1;
            ud_d   = ((cand_q[1] ^ cand_q[0]) != diff[0]);
          end
        end
      endcase
    end

    if (err_clr) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      cand_q   <= 2'b00;
      filt_q   <= 2'b00;
      cnt_q    <= '0;
      state_q  <= ST_INIT;
      step_q   <= 1'b0;
      ill_q    <= 1'b0;
      ud_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      cand_q   <= cand_d;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      step_q   <= step_d;
      ill_q    <= ill_d;
      ud_q     <= ud_d;
      err_q    <= err_d;
    end
  end

  assign step_out    = step_q;
  assign illegal_out = ill_q;
  assign up_down     = ud_q;
  assign err_count   = err_q;
  assign tracking    = (state_q == ST_TRACK);

endmodule

// File: tb/tb_quad_dir_decoder.sv
// Bench for quad_dir_decoder: directed scenarios plus random pin segments,
// checked every cycle against a segment-level reference model.
// Pins change only just after a rising edge; outputs are sampled 1 time unit after it.
module tb_quad_dir_decoder;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int EW   = 8;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          a_in = 1'b0;
  logic          b_in = 1'b0;
  logic          err_clr = 1'b0;
  logic          step_out, up_down, illegal_out, tracking;
  logic [EW-1:0] err_count;

  quad_dir_decoder #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ERR_CNT_W(EW)) dut (
    .clk(clk), .reset_in(reset_in), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
    .step_out(step_out), .up_down(up_down), .illegal_out(illegal_out),
    .err_count(err_count), .tracking(tracking)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // observed / expected vector: {tracking, up_down, illegal_out, step_out, err_count}
  logic [EW+3:0] obs  [MAXC];
  logic [EW+3:0] expv [MAXC];

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (cyc < MAXC) obs[cyc] = {tracking, up_down, illegal_out, step_out, err_count};
    end
  end

  // ---------------- reference model (pin segments -> events per edge) ----------
  bit m_step[MAXC], m_dir[MAXC], m_ill[MAXC], m_init[MAXC], m_rst[MAXC], m_clr[MAXC];
  logic [1:0] fwd [4];           // forward successor of each Gray code
  logic [1:0] m_filt = 2'b00;
  bit         m_trk_st = 1'b0;
  logic [1:0] pin_val = 2'b00;
  logic [1:0] seg_val = 2'b00;
  int         seg_start = 0;
  bit         seg_done = 1'b1;
  int         exp_done = 0;
  bit         e_ud = 1'b0, e_trk = 1'b0;
  logic [EW-1:0] e_err = '0;

  // A pin value held for at least D+1 edges is accepted S+D edges after it is first sampled.
  function automatic void model_close(int end_edge);
    int a;
    if (!seg_done && (end_edge - seg_start) >= D + 1) begin
      a = seg_start + S + D;
      seg_done = 1'b1;
      if (a < MAXC) begin
        if (!m_trk_st) begin
          m_init[a] = 1'b1;
          m_trk_st  = 1'b1;
          m_filt    = seg_val;
        end else if (seg_val != m_filt) begin
          if (fwd[m_filt] == seg_val) begin
            m_step[a] = 1'b1; m_dir[a] = 1'b0;
          end else if (fwd[seg_val] == m_filt) begin
            m_step[a] = 1'b1; m_dir[a] = 1'b1;
          end else begin
            m_ill[a] = 1'b1;
          end
          m_filt = seg_val;
        end
      end
    end
  endfunction

  function automatic void model_expand(int upto);
    for (int k = exp_done + 1; k <= upto && k < MAXC; k++) begin
      if (m_rst[k]) begin
        e_ud = 1'b0; e_err = '0; e_trk = 1'b0;
        expv[k] = '0;
      end else begin
        if (m_step[k]) e_ud = m_dir[k];
        if (m_ill[k] && e_err != '1) e_err = e_err + 1'b1;
        if (m_clr[k]) e_err = '0;
        if (m_init[k]) e_trk = 1'b1;
        expv[k] = {e_trk, e_ud, m_ill[k], m_step[k], e_err};
      end
    end
    exp_done = upto;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input logic [1:0] val, input int len);
    if (val != pin_val) begin
      model_close(cyc + 1);
      pin_val   = val;
      {a_in, b_in} = val;
      seg_val   = val;
      seg_start = cyc + 1;
      seg_done  = 1'b0;
    end
    repeat (len) tick();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    m_clr[cyc + 1] = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    int r;
    model_close(cyc + 1);
    for (int k = cyc + 1; k <= cyc + n + S + D + 2 && k < MAXC; k++) begin
      m_step[k] = 1'b0; m_ill[k] = 1'b0; m_init[k] = 1'b0; m_dir[k] = 1'b0;
    end
    for (int k = cyc + 1; k <= cyc + n; k++) m_rst[k] = 1'b1;
    r = cyc + n;
    m_filt = 2'b00; m_trk_st = 1'b0;
    // the synchronisers restart from 00 as if the pins had been 00 all along
    seg_val = 2'b00; seg_start = r - S; seg_done = 1'b0;
    reset_in = 1'b1;
    repeat (n) tick();
    reset_in = 1'b0;
    if (pin_val != 2'b00) begin
      model_close(r + 1);
      seg_val = pin_val; seg_start = r + 1; seg_done = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nst;
    do_reset(3);
    if (obs[3] !== '0) begin
      bad++; $display("FAIL reset_values got=%h want=%h", obs[3], {(EW+4){1'b0}});
    end
    total++;
    apply(2'b00, 10);
    model_close(cyc); model_expand(cyc);
    nst = 0;
    for (int k = 1; k <= cyc; k++) begin
      nst += obs[k][EW] + obs[k][EW+1];
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL reset_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (obs[cyc] !== {1'b1, 1'b0, 1'b0, 1'b0, {EW{1'b0}}}) begin
      bad++; $display("FAIL reset_idle_end got=%h want=%h", obs[cyc], {1'b1, {(EW+3){1'b0}}});
    end
    total++;
    if (nst != 0) begin
      bad++; $display("FAIL reset_idle_pulses got=%0d want=0", nst);
    end
  endtask

  task automatic test_forward();
    int t0, nst;
    t0 = cyc + 1;
    apply(2'b01, 12); apply(2'b11, 12); apply(2'b10, 12); apply(2'b00, 12);
    model_close(cyc); model_expand(cyc);
    nst = 0;
    for (int k = t0; k <= cyc; k++) begin
      nst += obs[k][EW];
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL forward_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (nst != 4) begin
      bad++; $display("FAIL forward_count got=%0d want=4", nst);
    end
    total++;
    if (obs[t0 + 6][EW] !== 1'b1 || obs[t0 + 5][EW] !== 1'b0) begin
      bad++; $display("FAIL forward_latency edge7=%b edge6=%b want 1,0", obs[t0 + 6][EW], obs[t0 + 5][EW]);
    end
  endtask

  task automatic test_reverse();
    int t0, nst;
    t0 = cyc + 1;
    apply(2'b10, 12); apply(2'b11, 12); apply(2'b01, 12);
    model_close(cyc); model_expand(cyc);
    nst = 0;
    for (int k = t0; k <= cyc; k++) begin
      nst += obs[k][EW];
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL reverse_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (nst != 3 || obs[cyc][EW+2] !== 1'b1) begin
      bad++; $display("FAIL reverse_count steps=%0d up_down=%b want 3,1", nst, obs[cyc][EW+2]);
    end
  endtask

  task automatic test_glitch();
    int t0, np;
    apply(2'b00, 12);
    t0 = cyc + 1;
    apply(2'b10, 3);
    apply(2'b00, 12);
    model_close(cyc); model_expand(cyc);
    np = 0;
    for (int k = t0; k <= cyc; k++) begin
      np += obs[k][EW] + obs[k][EW+1];
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL glitch_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (np != 0) begin
      bad++; $display("FAIL glitch_pulses got=%0d want=0", np);
    end
  endtask

  task automatic test_illegal();
    int t0, nil, nst;
    t0 = cyc + 1;
    apply(2'b11, 12); apply(2'b00, 12);
    model_close(cyc); model_expand(cyc);
    nil = 0; nst = 0;
    for (int k = t0; k <= cyc; k++) begin
      nil += obs[k][EW+1]; nst += obs[k][EW];
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL illegal_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (nil != 2 || nst != 0 || obs[cyc][EW-1:0] !== 8'd2 || obs[cyc][EW+2] !== 1'b1) begin
      bad++; $display("FAIL illegal_summary ill=%0d step=%0d err=%0d ud=%b want 2,0,2,1",
                      nil, nst, obs[cyc][EW-1:0], obs[cyc][EW+2]);
    end
    pulse_clr();
    tick();
    total++;
    if (err_count !== 8'd0) begin
      bad++; $display("FAIL err_clr got=%0d want=0", err_count);
    end
  endtask

  task automatic test_clr_wins();
    int t0;
    t0 = cyc + 1;
    apply(2'b11, 6);          // accept edge is t0+6
    pulse_clr();
    apply(2'b11, 6);
    model_close(cyc); model_expand(cyc);
    for (int k = t0; k <= cyc; k++) begin
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL clr_wins_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (obs[t0 + 6][EW+1] !== 1'b1 || obs[t0 + 6][EW-1:0] !== 8'd0) begin
      bad++; $display("FAIL clr_wins ill=%b err=%0d want 1,0", obs[t0 + 6][EW+1], obs[t0 + 6][EW-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    int t0, r, nst;
    t0 = cyc + 1;
    apply(2'b10, 3);          // forward move from 11, still debouncing
    do_reset(1);
    r = cyc;
    apply(2'b10, 12);
    model_close(cyc); model_expand(cyc);
    nst = 0;
    for (int k = t0; k <= cyc; k++) begin
      nst += obs[k][EW];
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL reset_mid_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (nst != 0 || obs[r] !== '0) begin
      bad++; $display("FAIL reset_mid steps=%0d state=%h want 0,0", nst, obs[r]);
    end
    total++;
    if (obs[r + 6][EW+3] !== 1'b0 || obs[r + 7][EW+3] !== 1'b1) begin
      bad++; $display("FAIL reset_mid_tracking r+6=%b r+7=%b want 0,1", obs[r + 6][EW+3], obs[r + 7][EW+3]);
    end
  endtask

  task automatic test_saturation();
    int t0;
    t0 = cyc + 1;
    for (int i = 0; i < 260; i++) apply((i % 2 == 0) ? 2'b01 : 2'b10, 6);
    model_close(cyc); model_expand(cyc);
    for (int k = t0; k <= cyc; k++) begin
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL sat_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    total++;
    if (err_count !== 8'hFF) begin
      bad++; $display("FAIL saturation got=%0d want=255", err_count);
    end
  endtask

  task automatic test_random();
    int t0, len;
    logic [1:0] v;
    t0 = cyc + 1;
    for (int i = 0; i < 60; i++) begin
      v = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
      apply(v, len);
      if ($urandom_range(0, 5) == 0) pulse_clr();
    end
    apply(pin_val, 12);
    model_close(cyc); model_expand(cyc);
    for (int k = t0; k <= cyc; k++) begin
      total++;
      if (obs[k] !== expv[k]) begin
        bad++; $display("FAIL random_cycle k=%0d got=%h want=%h", k, obs[k], expv[k]);
      end
    end
  endtask

  initial begin
    fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[3] = 2'b10; fwd[2] = 2'b00;
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_clr_wins();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
